dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`) between the CPU core (port 0) and a DMA/debug master (port 1). Each cycle it grants at most one request, drives the winner's command onto the `dmem` port, and returns a registered completion with read data one cycle later. The core has fixed priority, and an anti-starvation counter guarantees the DMA port a slot after `MAX_BURST` consecutive contested core grants. The block sits between the core/DMA and `dmem`, in the same clock domain.

## Interface
- `MAX_BURST`, default 4: maximum consecutive core grants while DMA is waiting. Legal range is 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request from core (0) and DMA (1).
- `we0`, `we1`  in  2  write code: 00 = read, 01 = SW, 10 = SH, 11 = SB.
- `size0`, `size1`  in  3  load size: 000 = LW, 001 = LH, 010 = LB, 011 = LBU, 101 = LHU. Ignored on writes.
- `addr0`, `addr1`  in  32  byte address.
- `wdata0`, `wdata1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  combinational grant. The command is accepted at the rising edge ending the grant cycle.
- `rvalid0`, `rvalid1`  out  1  registered one-cycle completion pulse.
- `rdata0`, `rdata1`  out  32  registered read data. Valid while the matching `rvalid` is high.
- `MemWrite`  out  2  to `dmem`.
- `SizeLoad`  out  3  to `dmem`.
- `a`  out  32  to `dmem`.
- `wd`  out  32  to `dmem`.
- `rd`  in  32  from `dmem` (combinational read).

## Operation
- Requester rules:
  - Holds `req`, `we`, `size`, `addr`, `wdata` stable from assertion until the cycle `gnt` is high.
  - May keep `req` high for back-to-back transactions.
  - Must not drop `req` before it is granted.
- Grant selection (combinational), in priority order:
  - Only `req0` high: grant 0.
  - Only `req1` high: grant 1.
  - Both high and `starve_cnt == MAX_BURST`: grant 1.
  - Both high otherwise: grant 0.
  - `gnt0` and `gnt1` are never both high.
- `starve_cnt` register, width $clog2(MAX_BURST+1):
  - Increments when `gnt0` is granted while `req1` is high.
  - Clears to 0 when `gnt1` is granted or `req1` is low.
  - Saturates at `MAX_BURST`.
- Memory drive:
  - In a grant cycle, `MemWrite`/`SizeLoad`/`a` carry the winner's `we`/`size`/`addr`.
  - `wd` carries the winner's `wdata` on writes only. It is forced to 0 on reads so stale write data never reaches the `dmem` read path.
  - With no grant: `MemWrite`=00, `SizeLoad`=111 (`dmem` returns 0), `a`=0, `wd`=0. No memory side effect occurs.
- Completion, registered at the edge ending the grant cycle:
  - The granted port's `rvalid` is set for exactly one cycle.
  - On a read, `rdata` is loaded with `rd`. On a write, `rdata` is loaded with 0.
  - The non-granted port's `rdata` holds its previous value.
- Write ordering: a write granted in cycle N is visible to a read granted in cycle N+1 from either port.

## Timing
- Reset values: `gnt0`=`gnt1`=0 (forced while `reset` is high), `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0, `starve_cnt`=0. Memory outputs take their idle values.
- Latency: `req` seen with `gnt` in cycle N, then `rvalid`/`rdata` in cycle N+1. A single uncontested requester sees `gnt` in the same cycle `req` rises.
- Throughput: one transaction per cycle in total. A requester holding `req` high alone is granted every cycle and gets `rvalid` every cycle.
- Contested steady state with `MAX_BURST`=M: grant sequence is M × port 0, then 1 × port 1, repeating.
- Reset mid-operation:
  - A grant cycle interrupted by `reset` performs no write (the async clear forces idle).
  - A pending `rvalid` is cleared.
  - `starve_cnt` returns to 0.
- Simultaneous request and completion: a new grant in cycle N+1 coexists with `rvalid` for the cycle-N transaction. The same port may have `gnt` and `rvalid` high together.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs go to the values above immediately. `MemWrite`=00, `SizeLoad`=111.
- Core-only path: port 0 SW `addr`=0x10, `wdata`=0xDEADBEEF, then LW `addr`=0x10 → `gnt0` in both cycles. Second `rvalid0` has `rdata0`=0xDEADBEEF. First `rvalid0` has `rdata0`=0.
- Contention, `MAX_BURST`=4: `req0` and `req1` both held high for 15 cycles → grant order 0,0,0,0,1,0,0,0,0,1,0,0,0,0,1.
- Cross-port sub-word access: DMA SB `addr`=0x21, `wdata`=0x000000F0, then core LB and LBU at 0x21 → `rdata0`=0xFFFFFFF0 for LB, 0x000000F0 for LBU.
- Read with dirty `wdata`: port 1 LW with `wdata1`=4 → `wd`=0 on the memory port and the correct word is returned (not 0 or X).
- Reset after grant: assert `reset` in cycle N+1 after a read grant in cycle N → no `rvalid` pulse appears. After release, a fresh request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the CPU core (port 0)
// and a DMA/debug master (port 1). The core has fixed priority. A starvation
// counter hands the DMA port one slot after MAX_BURST contested core grants.
// Completions are registered and carry read data one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  we0,
  input  logic [1:0]  we1,
  input  logic [2:0]  size0,
  input  logic [2:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [1:0]  MemWrite,
  output logic [2:0]  SizeLoad,
  output logic [31:0] a,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  // Write codes on the dmem port; WR_NONE is a plain read.
  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_WORD = 2'b01,
    WR_HALF = 2'b10,
    WR_BYTE = 2'b11
  } wr_code_t;

  // SizeLoad value that makes dmem return 0 when nobody is granted.
  localparam logic [2:0] SIZE_IDLE = 3'b111;

  logic [CW-1:0] starve_cnt;
  logic          dma_due;

  assign dma_due = (starve_cnt == BURST_LIMIT);

  // Grant selection: DMA wins when alone or when its starvation budget is spent.
  // Both grants are forced low while reset is asserted so no write can slip in.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req1 && (!req0 || dma_due)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  // Count core grants that were won while the DMA port was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt1 || !req1) begin
      starve_cnt <= '0;
    end else if (gnt0 && !dma_due) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Drive the winner's command onto dmem; idle values when nobody is granted.
  // Write data is zeroed on reads so stale wdata never reaches the read path.
  always_comb begin
    MemWrite = WR_NONE;
    SizeLoad = SIZE_IDLE;
    a        = '0;
    wd       = '0;
    if (gnt0) begin
      MemWrite = we0;
      SizeLoad = size0;
      a        = addr0;
      wd       = (we0 != WR_NONE) ? wdata0 : '0;
    end else if (gnt1) begin
      MemWrite = we1;
      SizeLoad = size1;
      a        = addr1;
      wd       = (we1 != WR_NONE) ? wdata1 : '0;
    end
  end

  // Register completion: one-cycle rvalid for the winner, read data or 0 on writes.
  // The losing port's rdata holds its previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0) begin
        rdata0 <= (MemWrite == WR_NONE) ? rd : '0;
      end
      if (gnt1) begin
        rdata1 <= (MemWrite == WR_NONE) ? rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a byte-array dmem model on the memory port, and
// a reference model (separate byte array plus per-port expectations) that
// predicts grants, completions and the memory command from the arbitration rules.
module tb_dmem_arbiter;
  localparam int unsigned MB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0, req1;
  logic [1:0]  we0, we1;
  logic [2:0]  size0, size1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  MemWrite;
  logic [2:0]  SizeLoad;
  logic [31:0] a, wd, rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .MemWrite(MemWrite), .SizeLoad(SizeLoad), .a(a), .wd(wd), .rd(rd)
  );

  // Little-endian load extraction from an aligned word.
  function automatic logic [31:0] decode_load(input logic [2:0] sz, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (sz)
      3'b000:  return word;
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {{24{b[7]}}, b};
      3'b011:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Environment dmem: combinational read, write on the rising edge.
  logic [7:0] mem [0:255];

  always_comb rd = decode_load(SizeLoad, a[1:0],
                               {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}],
                                mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]});

  initial begin : dmem_env
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
    forever begin
      @(posedge clk);
      case (MemWrite)
        2'b01: begin
          mem[{a[7:2], 2'd0}] <= wd[7:0];
          mem[{a[7:2], 2'd1}] <= wd[15:8];
          mem[{a[7:2], 2'd2}] <= wd[23:16];
          mem[{a[7:2], 2'd3}] <= wd[31:24];
        end
        2'b10: begin
          mem[{a[7:1], 1'b0}] <= wd[7:0];
          mem[{a[7:1], 1'b1}] <= wd[15:8];
        end
        2'b11: mem[a[7:0]] <= wd[7:0];
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:255];
  int unsigned m_wait;          // core wins while DMA was waiting
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic        e_gnt0, e_gnt1;
  logic [1:0]  e_mw;
  logic [2:0]  e_sl;
  logic [31:0] e_a, e_wd;

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] ad);
    logic [7:0] base;
    base = {ad[7:2], 2'b00};
    return decode_load(sz, ad[1:0], {ref_mem[base + 8'd3], ref_mem[base + 8'd2],
                                     ref_mem[base + 8'd1], ref_mem[base]});
  endfunction

  task automatic ref_store(input logic [1:0] w, input logic [31:0] ad, input logic [31:0] d);
    int unsigned n, base;
    n    = (w == 2'b01) ? 4 : (w == 2'b10) ? 2 : 1;
    base = ad[7:0] & ~(n - 1);
    for (int unsigned k = 0; k < n; k++) ref_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_rd0 = '0;   m_rd1 = '0;
  endtask

  // Expected combinational outputs for the inputs currently applied.
  task automatic predict();
    e_gnt1 = !reset && req1 && (!req0 || m_wait >= MB);
    e_gnt0 = !reset && req0 && !e_gnt1;
    e_mw = 2'b00; e_sl = 3'b111; e_a = '0; e_wd = '0;
    if (e_gnt0) begin
      e_mw = we0; e_sl = size0; e_a = addr0; e_wd = (we0 == 2'b00) ? 32'h0 : wdata0;
    end else if (e_gnt1) begin
      e_mw = we1; e_sl = size1; e_a = addr1; e_wd = (we1 == 2'b00) ? 32'h0 : wdata1;
    end
  endtask

  // Apply the effects of the predicted grant at the clock edge.
  task automatic commit();
    logic [31:0] v;
    v = '0;
    if (e_gnt0 || e_gnt1) begin
      if (e_mw == 2'b00) v = ref_load(e_sl, e_a);
      else ref_store(e_mw, e_a, e_wd);
    end
    m_rv0 = e_gnt0;
    m_rv1 = e_gnt1;
    if (e_gnt0) m_rd0 = v;
    if (e_gnt1) m_rd1 = v;
    if (req1 && e_gnt0) m_wait = (m_wait < MB) ? m_wait + 1 : m_wait;
    else m_wait = 0;
  endtask

  task automatic set0(input logic r, input logic [1:0] w, input logic [2:0] s,
                      input logic [31:0] ad, input logic [31:0] d);
    req0 = r; we0 = w; size0 = s; addr0 = ad; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic [1:0] w, input logic [2:0] s,
                      input logic [31:0] ad, input logic [31:0] d);
    req1 = r; we1 = w; size1 = s; addr1 = ad; wdata1 = d;
  endtask

  task automatic settle();
    predict();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set0(1'b1, 2'b01, 3'b000, 32'h10, 32'h1234_5678);
    set1(1'b1, 2'b00, 3'b000, 32'h20, 32'h0);
    #2;
    vectors++;
    if ({gnt0, gnt1} !== 2'b00) begin
      miscompares++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1);
    end
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      miscompares++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1);
    end
    vectors++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h %h want 0 0", rdata0, rdata1);
    end
    vectors++;
    if (MemWrite !== 2'b00 || SizeLoad !== 3'b111 || a !== 32'h0 || wd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem: got mw=%b sl=%b a=%h wd=%h want 00 111 0 0", MemWrite, SizeLoad, a, wd);
    end
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    set1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    predict();
    tick();
  endtask

  task automatic test_core_only();
    set0(1'b1, 2'b01, 3'b000, 32'h10, 32'hDEAD_BEEF);
    settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++; $display("FAIL core_sw_gnt: got %b%b want 10", gnt0, gnt1);
    end
    vectors++;
    if (MemWrite !== 2'b01 || a !== 32'h10 || wd !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL core_sw_mem: got mw=%b a=%h wd=%h want 01 10 deadbeef", MemWrite, a, wd);
    end
    tick();
    set0(1'b1, 2'b00, 3'b000, 32'h10, 32'hA5A5_A5A5);
    settle();
    vectors++;
    if (gnt0 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 32'h0) begin
      miscompares++;
      $display("FAIL core_lw_issue: got gnt0=%b rvalid0=%b rdata0=%h want 1 1 0", gnt0, rvalid0, rdata0);
    end
    vectors++;
    if (wd !== 32'h0 || SizeLoad !== 3'b000) begin
      miscompares++; $display("FAIL core_lw_mem: got wd=%h sl=%b want 0 000", wd, SizeLoad);
    end
    tick();
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF || gnt0 !== 1'b0 || SizeLoad !== 3'b111) begin
      miscompares++;
      $display("FAIL core_lw_done: got rvalid0=%b rdata0=%h gnt0=%b sl=%b want 1 deadbeef 0 111",
               rvalid0, rdata0, gnt0, SizeLoad);
    end
    tick();
    settle();
    vectors++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL core_hold: got rvalid0=%b rdata0=%h want 0 deadbeef", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_contention();
    int seq [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    set0(1'b1, 2'b00, 3'b000, 32'h10, 32'h0);
    set1(1'b1, 2'b00, 3'b000, 32'h20, 32'h0);
    for (int i = 0; i < 15; i++) begin
      settle();
      vectors++;
      if (gnt1 !== (seq[i] == 1) || gnt0 !== (seq[i] == 0)) begin
        miscompares++;
        $display("FAIL contend_order[%0d]: got gnt0=%b gnt1=%b want port %0d", i, gnt0, gnt1, seq[i]);
      end
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1) begin
        miscompares++;
        $display("FAIL contend_rvalid[%0d]: got %b%b want %b%b", i, rvalid0, rvalid1, m_rv0, m_rv1);
      end
      tick();
    end
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    set1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid1 !== 1'b1 || rdata1 !== m_rd1) begin
      miscompares++; $display("FAIL contend_last: got rvalid1=%b rdata1=%h want 1 %h", rvalid1, rdata1, m_rd1);
    end
    tick();
  endtask

  task automatic test_cross_port();
    set1(1'b1, 2'b11, 3'b000, 32'h21, 32'h0000_00F0);
    settle();
    vectors++;
    if (gnt1 !== 1'b1 || MemWrite !== 2'b11 || a !== 32'h21 || wd !== 32'h0000_00F0) begin
      miscompares++;
      $display("FAIL cross_sb: got gnt1=%b mw=%b a=%h wd=%h want 1 11 21 f0", gnt1, MemWrite, a, wd);
    end
    tick();
    set1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    set0(1'b1, 2'b00, 3'b010, 32'h21, 32'h0);
    settle();
    vectors++;
    if (gnt0 !== 1'b1 || rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL cross_sb_done: got gnt0=%b rvalid1=%b rdata1=%h want 1 1 0", gnt0, rvalid1, rdata1);
    end
    tick();
    set0(1'b1, 2'b00, 3'b011, 32'h21, 32'h0);
    settle();
    vectors++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hFFFF_FFF0) begin
      miscompares++; $display("FAIL cross_lb: got rvalid0=%b rdata0=%h want 1 fffffff0", rvalid0, rdata0);
    end
    tick();
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h0000_00F0) begin
      miscompares++; $display("FAIL cross_lbu: got rvalid0=%b rdata0=%h want 1 000000f0", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_dirty_wdata();
    set1(1'b1, 2'b00, 3'b000, 32'h10, 32'h0000_0004);
    settle();
    vectors++;
    if (gnt1 !== 1'b1 || wd !== 32'h0 || MemWrite !== 2'b00 || a !== 32'h10) begin
      miscompares++;
      $display("FAIL dirty_mem: got gnt1=%b wd=%h mw=%b a=%h want 1 0 00 10", gnt1, wd, MemWrite, a);
    end
    tick();
    set1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL dirty_rdata: got rvalid1=%b rdata1=%h want 1 deadbeef", rvalid1, rdata1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    // Completion pending when reset hits mid-cycle.
    set0(1'b1, 2'b00, 3'b000, 32'h10, 32'h0);
    settle();
    tick();
    set0(1'b1, 2'b00, 3'b000, 32'h14, 32'h0);
    #2;
    vectors++;
    if (rvalid0 !== 1'b1 || gnt0 !== 1'b1) begin
      miscompares++; $display("FAIL rmid_pre: got rvalid0=%b gnt0=%b want 1 1", rvalid0, gnt0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'h0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_clear: got rvalid0=%b rdata0=%h gnt=%b%b want 0 0 00", rvalid0, rdata0, gnt0, gnt1);
    end
    vectors++;
    if (MemWrite !== 2'b00 || SizeLoad !== 3'b111 || a !== 32'h0) begin
      miscompares++; $display("FAIL rmid_mem: got mw=%b sl=%b a=%h want 00 111 0", MemWrite, SizeLoad, a);
    end
    model_reset();
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    predict();
    tick();
    // Write grant interrupted by reset must not reach memory.
    set0(1'b1, 2'b01, 3'b000, 32'h10, 32'h0BAD_F00D);
    #2;
    vectors++;
    if (gnt0 !== 1'b1) begin
      miscompares++; $display("FAIL rwr_pre: got gnt0=%b want 1", gnt0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (gnt0 !== 1'b0 || MemWrite !== 2'b00 || wd !== 32'h0) begin
      miscompares++; $display("FAIL rwr_block: got gnt0=%b mw=%b wd=%h want 0 00 0", gnt0, MemWrite, wd);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rvalid0 !== 1'b0) begin
      miscompares++; $display("FAIL rwr_norv: got rvalid0=%b want 0", rvalid0);
    end
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    predict();
    tick();
    // Fresh read after release sees the original word.
    set0(1'b1, 2'b00, 3'b000, 32'h10, 32'h0);
    settle();
    vectors++;
    if (gnt0 !== 1'b1 || rvalid0 !== 1'b0) begin
      miscompares++; $display("FAIL rfresh_gnt: got gnt0=%b rvalid0=%b want 1 0", gnt0, rvalid0);
    end
    tick();
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL rfresh_data: got rvalid0=%b rdata0=%h want 1 deadbeef", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic gen_cmd(output logic [1:0] w, output logic [2:0] s,
                         output logic [31:0] ad, output logic [31:0] d);
    logic [2:0] sizes [5];
    sizes[0] = 3'b000; sizes[1] = 3'b001; sizes[2] = 3'b010; sizes[3] = 3'b011; sizes[4] = 3'b101;
    w  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    s  = sizes[$urandom_range(0, 4)];
    ad = 32'($urandom_range(0, 63));
    if (w == 2'b01 || (w == 2'b00 && s == 3'b000)) ad[1:0] = 2'b00;
    else if (w == 2'b10 || (w == 2'b00 && (s == 3'b001 || s == 3'b101))) ad[0] = 1'b0;
    d = $urandom;
  endtask

  task automatic test_random();
    logic p0, p1;
    logic [1:0]  w;
    logic [2:0]  s;
    logic [31:0] ad, d;
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!p0) begin
        gen_cmd(w, s, ad, d);
        p0 = ($urandom_range(0, 3) != 0);
        set0(p0, w, s, ad, d);
      end
      if (!p1) begin
        gen_cmd(w, s, ad, d);
        p1 = ($urandom_range(0, 2) != 0);
        set1(p1, w, s, ad, d);
      end
      settle();
      vectors++;
      if (gnt0 !== e_gnt0 || gnt1 !== e_gnt1) begin
        miscompares++; $display("FAIL rnd_gnt c%0d: got %b%b want %b%b", c, gnt0, gnt1, e_gnt0, e_gnt1);
      end
      vectors++;
      if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1) begin
        miscompares++; $display("FAIL rnd_rvalid c%0d: got %b%b want %b%b", c, rvalid0, rvalid1, m_rv0, m_rv1);
      end
      vectors++;
      if (rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
        miscompares++;
        $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", c, rdata0, rdata1, m_rd0, m_rd1);
      end
      vectors++;
      if ({MemWrite, SizeLoad, a, wd} !== {e_mw, e_sl, e_a, e_wd}) begin
        miscompares++;
        $display("FAIL rnd_mem c%0d: got %b %b %h %h want %b %b %h %h",
                 c, MemWrite, SizeLoad, a, wd, e_mw, e_sl, e_a, e_wd);
      end
      tick();
      if (e_gnt0) p0 = 1'b0;
      if (e_gnt1) p1 = 1'b0;
    end
    set0(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    set1(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    settle();
    vectors++;
    if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
      miscompares++;
      $display("FAIL rnd_tail: got %b%b %h %h want %b%b %h %h",
               rvalid0, rvalid1, rdata0, rdata1, m_rv0, m_rv1, m_rd0, m_rd1);
    end
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    model_reset();
    test_reset();
    test_core_only();
    test_contention();
    test_cross_port();
    test_dirty_wdata();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
